// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: LC-3b EX/MEM pipeline register with hold/bubble/flush control and a hold watchdog.
// Defining EX_MEM_STATS_EN adds the stat_hold_cycles/stat_bubbles counters.
module ex_mem_stage_reg #(
  parameter int CTRL_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       ir_in,
  input  logic [15:0]       alu_in,
  input  logic [2:0]        dest_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              stall_n,
  input  logic              bubble,
  input  logic              flush,
  output logic              valid_out,
  output logic [15:0]       pc_out,
  output logic [15:0]       ir_out,
  output logic [15:0]       alu_out,
  output logic [2:0]        mem_dest,
  output logic [CTRL_W-1:0] mem_control,
  output logic              hold_active,
  output logic              hold_timeout
`ifdef EX_MEM_STATS_EN
  ,
  output logic [31:0]       stat_hold_cycles,
  output logic [31:0]       stat_bubbles
`endif
);
  typedef enum logic [1:0] {RUN, HOLD, BUBBLE} state_t;
  localparam logic [7:0] MAX = 8'(MAX_HOLD);
  state_t state;
  logic [7:0] hold_cnt;
  logic kill;
  assign kill = flush | bubble;
  assign hold_active = (state == HOLD);
  // flush outranks a stall, so it shares the load path with a forced NOP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      pc_out       <= '0;
      ir_out       <= '0;
      alu_out      <= '0;
      mem_dest     <= '0;
      mem_control  <= '0;
      hold_timeout <= 1'b0;
      hold_cnt     <= '0;
      state        <= RUN;
    end else if (stall_n || flush) begin
      valid_out    <= valid_in & ~kill;
      pc_out       <= kill ? '0 : pc_in;
      ir_out       <= kill ? '0 : ir_in;
      alu_out      <= kill ? '0 : alu_in;
      mem_dest     <= kill ? '0 : dest_in;
      mem_control  <= (kill || !valid_in) ? '0 : ctrl_in;
      hold_timeout <= hold_timeout & ~flush;
      hold_cnt     <= '0;
      state        <= (!flush && bubble) ? BUBBLE : RUN;
    end else begin
      hold_cnt     <= (hold_cnt >= MAX) ? hold_cnt : hold_cnt + 8'd1;
      hold_timeout <= hold_timeout | (hold_cnt >= MAX - 8'd1);
      state        <= HOLD;
    end
  end
`ifdef EX_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hold_cycles <= '0;
      stat_bubbles     <= '0;
    end else begin
      stat_hold_cycles <= stat_hold_cycles + {31'd0, !flush && !stall_n};
      stat_bubbles     <= stat_bubbles + {31'd0, !flush && stall_n && bubble};
    end
  end
`endif
endmodule
